// File: rtl/bp_fe_pkg.sv
// Shared types for the front-end predictor write-port scheduler.
// Holds the scheduler FSM states and the port source select encoding.
package bp_fe_pkg;

    typedef enum logic {
        e_clear = 1'b0,
        e_run   = 1'b1
    } bp_fe_wport_state_e;

    typedef enum logic [2:0] {
        e_src_none   = 3'd0,
        e_src_clear  = 3'd1,
        e_src_redir  = 3'd2,
        e_src_head   = 3'd3,
        e_src_bypass = 3'd4
    } bp_fe_wport_src_e;

endpackage

// File: rtl/bp_fe_pred_wport_fifo.sv
// Small attaboy FIFO: valid/ready on the write side, valid/yumi on the read side.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module bp_fe_pred_wport_fifo #(
    parameter int els_p   = 4,
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int lg_els_lp = $clog2(els_p);

    logic [width_p-1:0] mem [els_p];
    logic [lg_els_lp:0] wr_ptr, rd_ptr;
    logic               enq, deq;

    assign v_o     = (wr_ptr != rd_ptr);
    assign ready_o = ~((wr_ptr[lg_els_lp] != rd_ptr[lg_els_lp])
                     && (wr_ptr[lg_els_lp-1:0] == rd_ptr[lg_els_lp-1:0]));
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign data_o  = mem[rd_ptr[lg_els_lp-1:0]];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + (lg_els_lp+1)'(1);
            if (deq) rd_ptr <= rd_ptr + (lg_els_lp+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem[wr_ptr[lg_els_lp-1:0]] <= data_i;
    end

endmodule

// File: rtl/bp_fe_pred_wport_sched.sv
// Arbitrates the single predictor-table write port between redirects and attaboys,
// and runs the post-reset clear sweep that gates init_done.
//
// state   | meaning
// e_clear | sweeping every table row with zero; attaboys refused, redirects held
// e_run   | normal arbitration; terminal until reset
module bp_fe_pred_wport_sched
    import bp_fe_pkg::*;
#(
    parameter int idx_width_p    = 9,
    parameter int data_width_p   = 64,
    parameter int ab_els_p       = 4,
    parameter int starve_limit_p = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    redir_v_i,
    input  logic [idx_width_p-1:0]  redir_idx_i,
    input  logic [data_width_p-1:0] redir_data_i,
    input  logic                    ab_v_i,
    input  logic [idx_width_p-1:0]  ab_idx_i,
    input  logic [data_width_p-1:0] ab_data_i,
    output logic                    ab_ready_o,
    output logic                    w_v_o,
    output logic                    w_clr_o,
    output logic [idx_width_p-1:0]  w_idx_o,
    output logic [data_width_p-1:0] w_data_o,
    input  logic                    w_yumi_i,
    output logic                    init_done_o,
    output logic                    redir_drop_o
);

    localparam int starve_w_lp = $clog2(starve_limit_p + 1);
    localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(starve_limit_p);
    localparam int ent_w_lp = idx_width_p + data_width_p;

    bp_fe_wport_state_e      state_r;
    bp_fe_wport_src_e        src;
    logic [idx_width_p-1:0]  clear_idx_r;
    logic                    redir_v_r;
    logic [idx_width_p-1:0]  redir_idx_r;
    logic [data_width_p-1:0] redir_data_r;
    logic [starve_w_lp-1:0]  starve_cnt;
    logic                    running, forced, yumi, redir_issue;
    logic                    head_v, fifo_ready, fifo_enq_v, fifo_yumi;
    logic [ent_w_lp-1:0]     head_ent;

    assign running = (state_r == e_run);
    assign forced  = head_v & (starve_cnt == starve_max_lp);

    always_comb begin
        src = e_src_none;
        if (!running)                    src = e_src_clear;
        else if (forced)                 src = e_src_head;
        else if (redir_v_r || redir_v_i) src = e_src_redir;
        else if (head_v)                 src = e_src_head;
        else if (ab_v_i)                 src = e_src_bypass;
    end

    always_comb begin
        w_v_o    = (src != e_src_none);
        w_clr_o  = (src == e_src_clear);
        w_idx_o  = '0;
        w_data_o = '0;
        case (src)
            e_src_clear:  w_idx_o = clear_idx_r;
            e_src_redir: begin
                // A pending entry is always the newest redirect that has not been lost.
                if (redir_v_r) begin
                    w_idx_o  = redir_idx_r;
                    w_data_o = redir_data_r;
                end else begin
                    w_idx_o  = redir_idx_i;
                    w_data_o = redir_data_i;
                end
            end
            e_src_head:   {w_idx_o, w_data_o} = head_ent;
            e_src_bypass: begin
                w_idx_o  = ab_idx_i;
                w_data_o = ab_data_i;
            end
            default: ;
        endcase
    end

    assign yumi         = w_yumi_i & w_v_o;
    assign redir_issue  = (src == e_src_redir) & yumi;
    assign redir_drop_o = redir_v_i & redir_v_r & ~redir_issue;
    assign ab_ready_o   = running & fifo_ready;
    assign fifo_enq_v   = ab_v_i & running & ~((src == e_src_bypass) & yumi);
    assign fifo_yumi    = (src == e_src_head) & yumi;
    assign init_done_o  = running;

    bp_fe_pred_wport_fifo #(
        .els_p   (ab_els_p),
        .width_p (ent_w_lp)
    ) ab_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (fifo_enq_v),
        .data_i  ({ab_idx_i, ab_data_i}),
        .ready_o (fifo_ready),
        .v_o     (head_v),
        .data_o  (head_ent),
        .yumi_i  (fifo_yumi)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r      <= e_clear;
            clear_idx_r  <= '0;
            redir_v_r    <= 1'b0;
            redir_idx_r  <= '0;
            redir_data_r <= '0;
            starve_cnt   <= '0;
        end else begin
            if (!running && w_yumi_i) begin
                clear_idx_r <= clear_idx_r + idx_width_p'(1);
                if (&clear_idx_r) state_r <= e_run;
            end

            // A pass-through redirect consumed this cycle leaves nothing behind.
            if (redir_v_i) begin
                redir_v_r    <= ~(~redir_v_r & redir_issue);
                redir_idx_r  <= redir_idx_i;
                redir_data_r <= redir_data_i;
            end else if (redir_issue) begin
                redir_v_r <= 1'b0;
            end

            if (!head_v || fifo_yumi)
                starve_cnt <= '0;
            else if (src != e_src_head && starve_cnt != starve_max_lp)
                starve_cnt <= starve_cnt + starve_w_lp'(1);
        end
    end

endmodule

// File: tb/tb_bp_fe_pred_wport_sched.sv
// Vector-table bench for the predictor write-port scheduler; write payloads are
// checked against scoreboard queues filled as stimulus is driven.
module tb_bp_fe_pred_wport_sched;

    localparam int IW = 3;
    localparam int DW = 16;
    localparam int S_NONE = 0, S_CLR = 1, S_RED = 2, S_AB = 3;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          redir_v_i;
    logic [IW-1:0] redir_idx_i;
    logic [DW-1:0] redir_data_i;
    logic          ab_v_i;
    logic [IW-1:0] ab_idx_i;
    logic [DW-1:0] ab_data_i;
    logic          ab_ready_o;
    logic          w_v_o;
    logic          w_clr_o;
    logic [IW-1:0] w_idx_o;
    logic [DW-1:0] w_data_o;
    logic          w_yumi_i;
    logic          init_done_o;
    logic          redir_drop_o;

    bp_fe_pred_wport_sched #(
        .idx_width_p    (IW),
        .data_width_p   (DW),
        .ab_els_p       (4),
        .starve_limit_p (8)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .redir_v_i    (redir_v_i),
        .redir_idx_i  (redir_idx_i),
        .redir_data_i (redir_data_i),
        .ab_v_i       (ab_v_i),
        .ab_idx_i     (ab_idx_i),
        .ab_data_i    (ab_data_i),
        .ab_ready_o   (ab_ready_o),
        .w_v_o        (w_v_o),
        .w_clr_o      (w_clr_o),
        .w_idx_o      (w_idx_o),
        .w_data_o     (w_data_o),
        .w_yumi_i     (w_yumi_i),
        .init_done_o  (init_done_o),
        .redir_drop_o (redir_drop_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          rv;
        logic [IW-1:0] ridx;
        logic          av;
        logic [IW-1:0] aidx;
        logic [DW-1:0] adata;
        logic          yumi;
        logic          e_wv;
        logic          e_rdy;
        logic          e_drop;
        logic          e_done;
        int            e_src;
    } vec_t;

    typedef struct {
        logic          clr;
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } wr_t;

    vec_t vecs[$];
    wr_t  clr_q[$];
    wr_t  ab_q[$];
    wr_t  last_redir;
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   mark_starve;
    int   mark_reset;

    function automatic logic [DW-1:0] rdata(input logic [IW-1:0] i);
        return 16'hD000 | {13'd0, i};
    endfunction

    task automatic add(input logic rv, input logic [IW-1:0] ridx, input logic av,
                       input logic [IW-1:0] aidx, input logic [DW-1:0] adata,
                       input logic yumi, input logic e_wv, input logic e_rdy,
                       input logic e_drop, input logic e_done, input int e_src);
        vec_t v;
        v.rv = rv; v.ridx = ridx; v.av = av; v.aidx = aidx; v.adata = adata;
        v.yumi = yumi; v.e_wv = e_wv; v.e_rdy = e_rdy; v.e_drop = e_drop;
        v.e_done = e_done; v.e_src = e_src;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_clears();
        wr_t w;
        for (int i = 0; i < 8; i++) begin
            w.clr = 1'b1; w.idx = IW'(i); w.data = '0;
            clr_q.push_back(w);
        end
    endtask

    task automatic drive_idle();
        redir_v_i = 1'b0; redir_idx_i = '0; redir_data_i = '0;
        ab_v_i = 1'b0; ab_idx_i = '0; ab_data_i = '0; w_yumi_i = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_w_v"}, w_v_o, 1'b1);
        chk({tag, "_w_clr"}, w_clr_o, 1'b1);
        chk({tag, "_w_idx"}, w_idx_o, 0);
        chk({tag, "_w_data"}, w_data_o, 0);
        chk({tag, "_ab_ready"}, ab_ready_o, 1'b0);
        chk({tag, "_init_done"}, init_done_o, 1'b0);
        chk({tag, "_drop"}, redir_drop_o, 1'b0);
    endtask

    task automatic apply(input int k);
        vec_t v;
        wr_t  w;
        wr_t  exp;
        logic have;
        string tag;
        v = vecs[k];
        tag = $sformatf("v%0d", k);
        redir_v_i = v.rv; redir_idx_i = v.ridx; redir_data_i = rdata(v.ridx);
        ab_v_i = v.av; ab_idx_i = v.aidx; ab_data_i = v.adata; w_yumi_i = v.yumi;
        if (v.rv) begin
            last_redir.clr = 1'b0; last_redir.idx = v.ridx; last_redir.data = rdata(v.ridx);
        end
        if (v.av && v.e_rdy) begin
            w.clr = 1'b0; w.idx = v.aidx; w.data = v.adata;
            ab_q.push_back(w);
        end
        #2;
        n_vec++;
        chk({tag, "_w_v"}, w_v_o, v.e_wv);
        chk({tag, "_ab_ready"}, ab_ready_o, v.e_rdy);
        chk({tag, "_drop"}, redir_drop_o, v.e_drop);
        chk({tag, "_init_done"}, init_done_o, v.e_done);
        if (v.e_src != S_NONE && w_v_o && w_yumi_i) begin
            have = 1'b1;
            exp = last_redir;
            if (v.e_src == S_CLR) begin
                if (clr_q.size() == 0) have = 1'b0; else exp = clr_q.pop_front();
            end else if (v.e_src == S_AB) begin
                if (ab_q.size() == 0) have = 1'b0; else exp = ab_q.pop_front();
            end
            chk({tag, "_sb_entry"}, have, 1'b1);
            if (have) begin
                chk({tag, "_w_clr"}, w_clr_o, exp.clr);
                chk({tag, "_w_idx"}, w_idx_o, exp.idx);
                chk({tag, "_w_data"}, w_data_o, exp.data);
            end
        end
        @(negedge clk_i);
    endtask

    initial begin
        logic [IW-1:0] enq_idx[4];
        logic [IW-1:0] late_idx[4];
        enq_idx  = '{3'd1, 3'd2, 3'd3, 3'd6};
        late_idx = '{3'd1, 3'd2, 3'd4, 3'd5};
        reset_i = 1'b0;
        drive_idle();
        last_redir = '{clr: 1'b0, idx: '0, data: '0};

        // sweep with two redirects captured late in it; the second overwrites the first
        for (int i = 0; i < 8; i++)
            add(i == 6 || i == 7, (i == 6) ? 3'd3 : 3'd4, 0, 0, 0, 1, 1, 0, i == 7, 0, S_CLR);
        add(0, 0, 0, 0, 0, 1, 1, 1, 0, 1, S_RED);
        add(0, 0, 1, 3'd5, 16'h00AB, 1, 1, 1, 0, 1, S_AB);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, S_NONE);
        for (int j = 0; j < 4; j++)
            add(0, 0, 1, enq_idx[j], 16'h0010 + DW'(j), 0, 1, 1, 0, 1, S_NONE);
        add(0, 0, 1, 3'd7, 16'h00FF, 0, 1, 0, 0, 1, S_NONE);
        for (int j = 0; j < 4; j++)
            add(0, 0, 0, 0, 0, 1, 1, j != 0, 0, 1, S_AB);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, S_NONE);
        add(1, 3'd1, 0, 0, 0, 0, 1, 1, 0, 1, S_NONE);
        add(1, 3'd2, 0, 0, 0, 0, 1, 1, 1, 1, S_NONE);
        add(0, 0, 0, 0, 0, 1, 1, 1, 0, 1, S_RED);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, S_NONE);
        // starvation: one queued attaboy behind a continuous redirect stream
        add(1, 3'd0, 1, 3'd3, 16'h0033, 1, 1, 1, 0, 1, S_RED);
        for (int j = 1; j <= 8; j++)
            add(1, IW'(j), 0, 0, 0, 1, 1, 1, 0, 1, S_RED);
        add(1, 3'd7, 0, 0, 0, 1, 1, 1, 0, 1, S_AB);
        add(0, 0, 0, 0, 0, 1, 1, 1, 0, 1, S_RED);
        mark_starve = vecs.size();
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, S_NONE);
        for (int j = 0; j < 4; j++)
            add(0, 0, 1, late_idx[j], 16'h0061 + DW'(j), 0, 1, 1, 0, 1, S_NONE);
        add(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, S_AB);
        mark_reset = vecs.size();
        for (int i = 0; i < 8; i++)
            add(0, 0, 1, 3'd6, 16'h0077, 1, 1, 0, 0, 0, S_CLR);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, S_NONE);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, S_NONE);

        push_clears();
        #12;
        chk_reset_outputs("por");
        @(negedge clk_i);
        reset_i = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            if (k == mark_starve)
                chk("starve_cnt_cleared", dut.starve_cnt, 0);
            if (k == mark_reset) begin
                drive_idle();
                #2;
                reset_i = 1'b0;
                #1;
                chk_reset_outputs("mid_rst");
                ab_q.delete();
                push_clears();
                @(negedge clk_i);
                reset_i = 1'b1;
            end
            apply(k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
